// File: rtl/modsq_norm_pkg.sv
// Shared constants, state encoding and element typedefs for the modular-square
// result normalizer.
package modsq_norm_pkg;

  localparam int WORD_LEN   = 16;
  localparam int BIT_LEN    = 17;
  localparam int LANE_BITS  = 32;
  localparam int CARRY_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [BIT_LEN-1:0]  coeff_t;
  typedef logic [WORD_LEN-1:0] word_t;

endpackage

// File: rtl/modsq_result_normalizer_carry_step.sv
// One carry-propagation step: coeff + carry_in -> WORD_LEN-bit word and the
// carry that moves up into the next word.
module modsq_carry_step
  import modsq_norm_pkg::*;
(
  input  logic [BIT_LEN-1:0]    coeff,
  input  logic [CARRY_BITS-1:0] carry_in,
  output logic [WORD_LEN-1:0]   word,
  output logic [CARRY_BITS-1:0] carry_out
);

  logic [BIT_LEN:0] sum;

  // One extra bit of headroom is enough: max 2^17-1 + 2 < 2^18.
  assign sum       = {1'b0, coeff} + {{(BIT_LEN+1-CARRY_BITS){1'b0}}, carry_in};
  assign word      = sum[WORD_LEN-1:0];
  assign carry_out = sum[BIT_LEN:WORD_LEN];

endmodule

// File: rtl/modsq_result_normalizer.sv
// Serial carry-propagating normalizer for redundant squaring output.
// Optional build macro NORMALIZER_LANE_CHECK_EN adds a sticky upper-lane-bits check.
module modsq_result_normalizer
  import modsq_norm_pkg::*;
#(
  parameter int MOD_LEN            = 1024,
  parameter int REDUNDANT_ELEMENTS = 1,
  localparam int NUM_ELEMENTS      = MOD_LEN/WORD_LEN + REDUNDANT_ELEMENTS,
  localparam int IN_BITS           = NUM_ELEMENTS*LANE_BITS
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic [IN_BITS-1:0]           in_coeffs,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
  output logic [1:0]                   carry_out,
  output logic                         busy,
  output logic                         overrun,
  output logic                         lane_err
);

  localparam int IDX_W = $clog2(NUM_ELEMENTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS-1);

  state_t                                  state_q, state_d;
  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]    coeff_q, coeff_d;
  logic [NUM_ELEMENTS-1:0][WORD_LEN-1:0]   result_q, result_d;
  logic [CARRY_BITS-1:0]                   carry_q, carry_d;
  logic [CARRY_BITS-1:0]                   carry_out_q, carry_out_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic                                    out_valid_q, out_valid_d;
  logic                                    overrun_q, overrun_d;

  logic                                    accept;
  logic [WORD_LEN-1:0]                     step_word;
  logic [CARRY_BITS-1:0]                   step_carry;

  // The coefficient register shifts down each NORM cycle, so the active
  // coefficient is always at position 0.
  modsq_carry_step u_step (
    .coeff     (coeff_q[0]),
    .carry_in  (carry_q),
    .word      (step_word),
    .carry_out (step_carry)
  );

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    coeff_d     = coeff_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    case (state_q)
      NORM: begin
        result_d[idx_q] = step_word;
        carry_d         = step_carry;
        coeff_d         = {{BIT_LEN{1'b0}}, coeff_q[NUM_ELEMENTS-1:1]};
        idx_d           = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          carry_out_d = step_carry;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance overrides the DONE->IDLE step so back-to-back jobs skip IDLE.
    if (accept) begin
      for (int j = 0; j < NUM_ELEMENTS; j++)
        coeff_d[j] = in_coeffs[j*LANE_BITS +: BIT_LEN];
      carry_d = '0;
      idx_d   = '0;
      state_d = NORM;
    end

    if (in_valid && !in_ready)
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      coeff_q     <= '0;
      result_q    <= '0;
      carry_q     <= '0;
      carry_out_q <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      coeff_q     <= coeff_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef NORMALIZER_LANE_CHECK_EN
  logic lane_err_q, lane_err_d;

  always_comb begin
    lane_err_d = lane_err_q;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      if (accept && (in_coeffs[j*LANE_BITS+BIT_LEN +: LANE_BITS-BIT_LEN] != '0))
        lane_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lane_err_q <= 1'b0;
    else          lane_err_q <= lane_err_d;
  end

  assign lane_err = lane_err_q;
`else
  assign lane_err = 1'b0;
`endif

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
